alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Shared-ALU scheduler in front of the combinational ALU (OPA/OPB, kernelsel, FUNTYPE/FUNCODE → result, CPSR).
- Arbitrates two requesters (port 0 = core pipeline, port 1 = convolution unit) with round-robin fairness.
- Drives the ALU from registered operands and returns result plus flags on a valid/ready response channel.
- Supports a kernel-sweep mode: one request runs the ALU three times with kernelsel 0,1,2 and returns the accumulated result.

Parameters:
BUS, 4, operand/result width; must match the ALU `bus` parameter.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous and active-low; one clock, no other clock domains
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester accept; at most one bit high per cycle
req_opa  in  2*BUS  operand A; requester i in bits [i*BUS +: BUS]
req_opb  in  2*BUS  operand B, same packing
req_funtype  in  4  FUNTYPE, 2 bits per requester
req_funcode  in  4  FUNCODE, 2 bits per requester
req_ksel  in  4  kernel select, 2 bits per requester; ignored when sweep is set
req_sweep  in  2  per-requester sweep-mode flag
alu_opa  out  BUS  to ALU OPA
alu_opb  out  BUS  to ALU OPB
alu_kernelsel  out  2  to ALU kernelsel
alu_funtype  out  2  to ALU FUNTYPE
alu_funcode  out  2  to ALU FUNCODE
alu_result  in  BUS  from ALU result
alu_cpsr  in  4  from ALU CPSR
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  1  index of the requester that owns the response
rsp_result  out  BUS  result or sweep accumulation
rsp_cpsr  out  4  CPSR captured from the final ALU pass
busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset (rst_n=0, async) → IDLE.
- Reset values: all alu_* = 0; rsp_valid = 0; rsp_id = 0; rsp_result = 0; rsp_cpsr = 0; busy = 0; req_ready = 0; pass counter = 0; last_grant = 1 (so requester 0 wins the first tie).
- IDLE arbitration:
  - Grant = the only valid requester, or on a tie the requester != last_grant.
  - req_ready[grant] is combinational: high only in IDLE with req_valid[grant] high.
  - On the handshake: latch opa/opb/funtype/funcode/ksel/sweep/id; pass ← 0; go to EXEC.
- EXEC:
  - alu_* are driven from latched registers; alu_kernelsel = sweep ? pass : ksel.
  - Each edge: acc ← (pass==0) ? alu_result : (acc + alu_result) mod 2^BUS; cpsr_r ← alu_cpsr.
  - If sweep and pass < 2: pass++ and stay in EXEC. Otherwise go to RESP.
- RESP:
  - rsp_valid = 1; rsp_result = acc; rsp_cpsr = cpsr_r; rsp_id = latched id.
  - Outputs stay stable while rsp_ready = 0.
  - On rsp_valid & rsp_ready: go to IDLE and set last_grant ← id.
- alu_* outputs hold their last values outside EXEC (no glitching to 0).
- Latency, from handshake edge T:
  - Normal op: rsp_valid at T+2.
  - Sweep: rsp_valid at T+4.
  - Earliest next accept is the cycle after the response handshake; there is no bypass.
- Throughput: at most one normal op per 3 cycles.
- Requesters must hold their fields stable while req_valid is high and not accepted; fields are sampled only at the handshake.
- Sweep flags: only the final-pass CPSR is reported. Intermediate carries and accumulation overflow are discarded (wrap mod 2^BUS).
- Unsupported FUNTYPE/FUNCODE values are passed through unchanged; the scheduler does not decode ops.
- Reset asserted mid-EXEC or mid-RESP: the in-flight op is dropped, no response is produced, and all registers return to reset values immediately.
- req_valid deasserted after grant has no effect; the op completes.

Test Plan:
1. req0: ADD (funtype 00, funcode 00), OPA=2, OPB=1 → req_ready[0] in accept cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_result=0011.
2. req1: ADD, OPA=7, OPB=7 → rsp_id=1, rsp_result=1110, rsp_cpsr=1000; then req1: SUB (funcode 01), 3−1 → rsp_result=0010.
3. Both valid every cycle with rsp_ready=1 → grants alternate 0,1,0,1; first grant after reset goes to 0; each grant is 3 cycles apart.
4. req0 sweep, ADD, OPA=7, OPB=7 → alu_kernelsel sequence 0,1,2 on consecutive cycles; rsp_result = 42 mod 16 = 1010; rsp_cpsr=1000; rsp_valid at T+4.
5. rsp_ready held low 5 cycles → rsp_* stable; busy=1; req_ready=00 throughout; accept resumes the cycle after rsp_ready rises.
6. rst_n pulsed low during the second sweep pass → busy, rsp_valid and alu_* go to 0 immediately; after release, a tie is granted to requester 0.

Source files
------------

// File: rtl/alu_sched.sv
// ---------------------------------------------------------------------------------------------
// alu_sched: shared-ALU scheduler.
//
// Two requesters (0 = core pipeline, 1 = convolution unit) compete for one combinational ALU.
// A round-robin arbiter grants one request at a time. The granted fields are latched and drive
// the ALU for one pass (normal op) or three passes with kernelsel 0,1,2 (sweep). In sweep mode
// the pass results are summed. The result and the final-pass CPSR are then returned on a
// valid/ready response channel.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid_i[1:0]     per-requester request valid
//   req_ready_o[1:0]     per-requester accept (one-hot or zero, combinational, IDLE only)
//   req_opa_i/opb_i      operands, requester i in bits [i*BUS +: BUS]
//   req_funtype_i        FUNTYPE, 2 bits per requester
//   req_funcode_i        FUNCODE, 2 bits per requester
//   req_ksel_i           kernel select, 2 bits per requester (ignored in sweep)
//   req_sweep_i          per-requester sweep flag
//   alu_*_o              operands/controls to the ALU; hold their values outside EXEC
//   alu_result_i/cpsr_i  ALU outputs
//   rsp_valid_o/ready_i  response handshake
//   rsp_id_o             owner of the response
//   rsp_result_o         result, or wrapped sum of the three sweep passes
//   rsp_cpsr_o           CPSR of the final ALU pass
//   busy_o               high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------------------------
module alu_sched #(
   parameter int unsigned BUS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid_i,
   output logic [1:0]         req_ready_o,
   input  logic [2*BUS-1:0]   req_opa_i,
   input  logic [2*BUS-1:0]   req_opb_i,
   input  logic [3:0]         req_funtype_i,
   input  logic [3:0]         req_funcode_i,
   input  logic [3:0]         req_ksel_i,
   input  logic [1:0]         req_sweep_i,
   output logic [BUS-1:0]     alu_opa_o,
   output logic [BUS-1:0]     alu_opb_o,
   output logic [1:0]         alu_kernelsel_o,
   output logic [1:0]         alu_funtype_o,
   output logic [1:0]         alu_funcode_o,
   input  logic [BUS-1:0]     alu_result_i,
   input  logic [3:0]         alu_cpsr_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic               rsp_id_o,
   output logic [BUS-1:0]     rsp_result_o,
   output logic [3:0]         rsp_cpsr_o,
   output logic               busy_o
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q;
   logic             last_grant_q;
   logic             id_q;
   logic             sweep_q;
   logic [1:0]       pass_q;
   logic [BUS-1:0]   opa_q;
   logic [BUS-1:0]   opb_q;
   logic [1:0]       funtype_q;
   logic [1:0]       funcode_q;
   logic [1:0]       ksel_q;
   logic [BUS-1:0]   acc_q;
   logic [3:0]       cpsr_q;
   logic             rsp_valid_q;
   logic             busy_q;

   logic             grant;
   logic             accept;
   logic [BUS-1:0]   sel_opa;
   logic [BUS-1:0]   sel_opb;
   logic [1:0]       sel_funtype;
   logic [1:0]       sel_funcode;
   logic [1:0]       sel_ksel;
   logic             sel_sweep;

   // Round-robin: a lone requester wins; on a tie the one that did not own the last
   // completed response wins.
   always_comb begin
      grant = 1'b0;
      unique case (req_valid_i)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant_q;
         default: grant = 1'b0;
      endcase
   end

   always_comb begin
      req_ready_o = 2'b00;
      if (state_q == StIdle) begin
         req_ready_o = req_valid_i & (grant ? 2'b10 : 2'b01);
      end
   end

   assign accept = |(req_ready_o & req_valid_i);

   // Field select for the granted requester.
   always_comb begin
      sel_opa     = grant ? req_opa_i[2*BUS-1:BUS] : req_opa_i[BUS-1:0];
      sel_opb     = grant ? req_opb_i[2*BUS-1:BUS] : req_opb_i[BUS-1:0];
      sel_funtype = grant ? req_funtype_i[3:2]     : req_funtype_i[1:0];
      sel_funcode = grant ? req_funcode_i[3:2]     : req_funcode_i[1:0];
      sel_ksel    = grant ? req_ksel_i[3:2]        : req_ksel_i[1:0];
      sel_sweep   = grant ? req_sweep_i[1]         : req_sweep_i[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         sweep_q      <= 1'b0;
         pass_q       <= 2'd0;
         opa_q        <= '0;
         opb_q        <= '0;
         funtype_q    <= 2'd0;
         funcode_q    <= 2'd0;
         ksel_q       <= 2'd0;
         acc_q        <= '0;
         cpsr_q       <= 4'd0;
         rsp_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  opa_q     <= sel_opa;
                  opb_q     <= sel_opb;
                  funtype_q <= sel_funtype;
                  funcode_q <= sel_funcode;
                  ksel_q    <= sel_ksel;
                  sweep_q   <= sel_sweep;
                  id_q      <= grant;
                  pass_q    <= 2'd0;
                  busy_q    <= 1'b1;
                  state_q   <= StExec;
               end
            end
            StExec: begin
               // Sweep accumulation wraps; intermediate CPSRs are overwritten.
               acc_q  <= (pass_q == 2'd0) ? alu_result_i : acc_q + alu_result_i;
               cpsr_q <= alu_cpsr_i;
               if (sweep_q && (pass_q < 2'd2)) begin
                  pass_q <= pass_q + 2'd1;
               end else begin
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end
            end
            StResp: begin
               if (rsp_ready_i) begin
                  rsp_valid_q  <= 1'b0;
                  busy_q       <= 1'b0;
                  last_grant_q <= id_q;
                  state_q      <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // ALU is fed straight from the latched fields so it holds steady outside EXEC.
   assign alu_opa_o       = opa_q;
   assign alu_opb_o       = opb_q;
   assign alu_funtype_o   = funtype_q;
   assign alu_funcode_o   = funcode_q;
   assign alu_kernelsel_o = sweep_q ? pass_q : ksel_q;

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = id_q;
   assign rsp_result_o = acc_q;
   assign rsp_cpsr_o   = cpsr_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;

   localparam int BUS = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       req_valid = '0;
   logic [1:0]       req_ready;
   logic [2*BUS-1:0] req_opa = '0;
   logic [2*BUS-1:0] req_opb = '0;
   logic [3:0]       req_funtype = '0;
   logic [3:0]       req_funcode = '0;
   logic [3:0]       req_ksel = '0;
   logic [1:0]       req_sweep = '0;
   logic [BUS-1:0]   alu_opa, alu_opb, alu_result;
   logic [1:0]       alu_kernelsel, alu_funtype, alu_funcode;
   logic [3:0]       alu_cpsr;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic             rsp_id;
   logic [BUS-1:0]   rsp_result;
   logic [3:0]       rsp_cpsr;
   logic             busy;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   alu_sched #(.BUS(BUS)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .req_opa_i       (req_opa),
      .req_opb_i       (req_opb),
      .req_funtype_i   (req_funtype),
      .req_funcode_i   (req_funcode),
      .req_ksel_i      (req_ksel),
      .req_sweep_i     (req_sweep),
      .alu_opa_o       (alu_opa),
      .alu_opb_o       (alu_opb),
      .alu_kernelsel_o (alu_kernelsel),
      .alu_funtype_o   (alu_funtype),
      .alu_funcode_o   (alu_funcode),
      .alu_result_i    (alu_result),
      .alu_cpsr_i      (alu_cpsr),
      .rsp_valid_o     (rsp_valid),
      .rsp_ready_i     (rsp_ready),
      .rsp_id_o        (rsp_id),
      .rsp_result_o    (rsp_result),
      .rsp_cpsr_o      (rsp_cpsr),
      .busy_o          (busy)
   );

   // Stand-in ALU. CPSR = {N, Z, C, 0}; C is carry for ADD, borrow for SUB.
   function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] ft, input logic [1:0] fc,
                                        input logic [1:0] ks);
      logic [4:0] w;
      logic [3:0] r;
      logic       c;
      c = 1'b0;
      r = 4'd0;
      case (ft)
         2'b00: begin
            case (fc)
               2'b00: begin w = {1'b0, a} + {1'b0, b}; r = w[3:0]; c = w[4]; end
               2'b01: begin r = a - b; c = (a < b); end
               2'b10: r = a & b;
               default: r = a | b;
            endcase
         end
         2'b01: r = a + {2'b00, ks};
         2'b10: r = a ^ b ^ {fc, ks};
         default: r = ~(a ^ b ^ {fc, ks});
      endcase
      return {r[3], (r == 4'd0), c, 1'b0, r};
   endfunction

   always_comb {alu_cpsr, alu_result} = alu_f(alu_opa, alu_opb, alu_funtype, alu_funcode,
                                              alu_kernelsel);

   // Expected {cpsr, result} for a whole request.
   function automatic logic [7:0] expect_f(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] ft, input logic [1:0] fc,
                                           input logic [1:0] ks, input logic sw);
      int         sum;
      logic [7:0] t;
      logic [3:0] cp;
      if (!sw) return alu_f(a, b, ft, fc, ks);
      sum = 0;
      cp = 4'd0;
      for (int k = 0; k < 3; k++) begin
         t = alu_f(a, b, ft, fc, 2'(k));
         sum += int'(t[3:0]);
         cp = t[7:4];
      end
      return {cp, 4'(sum % 16)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] ft, input logic [1:0] fc, input logic [1:0] ks,
                          input logic sw);
      req_opa[i*4 +: 4]     = a;
      req_opb[i*4 +: 4]     = b;
      req_funtype[i*2 +: 2] = ft;
      req_funcode[i*2 +: 2] = fc;
      req_ksel[i*2 +: 2]    = ks;
      req_sweep[i]          = sw;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 2'b00;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      int         port;
      logic [3:0] a, b;
      logic [1:0] ft, fc, ks;
      logic       sw;
      logic [3:0] er, ec;
   } vec_t;

   vec_t vt[11];

   // Single request through the table; rsp_ready held high.
   task automatic run_op(input vec_t v, input int idx);
      bit got;
      int lat;
      @(posedge clk);
      #1;
      set_req(v.port, v.a, v.b, v.ft, v.fc, v.ks, v.sw);
      req_valid = (v.port == 1) ? 2'b10 : 2'b01;
      rsp_ready = 1'b1;
      got = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req_ready[v.port]) begin got = 1; break; end
      end
      check($sformatf("vec%0d_ready", idx), {31'd0, got}, 32'd1);
      if (!got) begin req_valid = 2'b00; return; end
      check($sformatf("vec%0d_ready_onehot", idx), req_ready, req_valid);
      @(posedge clk);
      #1 req_valid = 2'b00;
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (rsp_valid) begin lat = n; break; end
      end
      check($sformatf("vec%0d_latency", idx), lat, v.sw ? 4 : 2);
      check($sformatf("vec%0d_id", idx), rsp_id, v.port);
      check($sformatf("vec%0d_result", idx), rsp_result, v.er);
      check($sformatf("vec%0d_cpsr", idx), rsp_cpsr, v.ec);
      @(posedge clk);
   endtask

   typedef struct {
      logic       id;
      logic [3:0] res, cp;
      int         lat;
   } exp_t;

   initial begin
      exp_t       q[$];
      exp_t       e;
      logic [7:0] x;
      logic [1:0] acc, exp_ready;
      int         gcyc[$];
      int         gid[$];
      int         last_m, acc_cyc, g, lat;
      bit         outst, seen;

      vt[0]  = '{0, 4'd2,  4'd1,  2'b00, 2'b00, 2'd0, 1'b0, 4'h3, 4'b0000};
      vt[1]  = '{1, 4'd7,  4'd7,  2'b00, 2'b00, 2'd0, 1'b0, 4'he, 4'b1000};
      vt[2]  = '{1, 4'd3,  4'd1,  2'b00, 2'b01, 2'd0, 1'b0, 4'h2, 4'b0000};
      vt[3]  = '{0, 4'd7,  4'd7,  2'b00, 2'b00, 2'd3, 1'b1, 4'ha, 4'b1000};
      vt[4]  = '{1, 4'hc,  4'ha,  2'b00, 2'b10, 2'd0, 1'b0, 4'h8, 4'b1000};
      vt[5]  = '{0, 4'd5,  4'd0,  2'b01, 2'b00, 2'd3, 1'b0, 4'h8, 4'b1000};
      vt[6]  = '{1, 4'd6,  4'd0,  2'b01, 2'b00, 2'd3, 1'b1, 4'h5, 4'b1000};
      vt[7]  = '{0, 4'd1,  4'd2,  2'b00, 2'b01, 2'd0, 1'b0, 4'hf, 4'b1010};
      vt[8]  = '{1, 4'd8,  4'd8,  2'b00, 2'b00, 2'd0, 1'b0, 4'h0, 4'b0110};
      vt[9]  = '{0, 4'd3,  4'd5,  2'b10, 2'b01, 2'd2, 1'b0, 4'h0, 4'b0100};
      vt[10] = '{1, 4'd1,  4'd0,  2'b11, 2'b10, 2'd1, 1'b0, 4'h7, 4'b0000};

      // Reset state
      @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_alu", {alu_opa, alu_opb, alu_kernelsel, alu_funtype, alu_funcode}, 0);
      check("rst_rsp", {rsp_id, rsp_result, rsp_cpsr}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 11; i++) run_op(vt[i], i);

      // Sweep: kernelsel walks 0,1,2
      @(posedge clk);
      #1;
      set_req(0, 4'd7, 4'd7, 2'b00, 2'b00, 2'd3, 1'b1);
      req_valid = 2'b01;
      @(negedge clk);
      check("sweep_ready", req_ready, 2'b01);
      @(posedge clk);
      #1 req_valid = 2'b00;
      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         check($sformatf("sweep_ksel%0d", p), alu_kernelsel, p);
         check($sformatf("sweep_busy%0d", p), {busy, rsp_valid}, 2'b10);
      end
      @(negedge clk);
      check("sweep_rsp", {rsp_valid, rsp_result, rsp_cpsr}, {1'b1, 4'ha, 4'b1000});
      @(posedge clk);

      // Fairness with both requesters always valid
      do_reset();
      set_req(0, 4'd1, 4'd1, 2'b00, 2'b00, 2'd0, 1'b0);
      set_req(1, 4'd2, 4'd2, 2'b00, 2'b00, 2'd0, 1'b0);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (|req_ready) begin gcyc.push_back(c); gid.push_back(int'(req_ready[1])); end
      end
      req_valid = 2'b00;
      check("rr_count", gcyc.size(), 5);
      for (int i = 0; i < gid.size() && i < 5; i++) begin
         check($sformatf("rr_id%0d", i), gid[i], i % 2);
         if (i > 0) check($sformatf("rr_gap%0d", i), gcyc[i] - gcyc[i-1], 3);
      end
      repeat (4) @(posedge clk);

      // Response backpressure
      #1;
      rsp_ready = 1'b0;
      set_req(0, 4'd2, 4'd1, 2'b00, 2'b00, 2'd0, 1'b0);
      req_valid = 2'b01;
      @(negedge clk);
      check("bp_accept", req_ready, 2'b01);
      @(posedge clk);
      #1 req_valid = 2'b11;
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp_hold%0d", c),
               {rsp_valid, busy, req_ready, rsp_id, rsp_result, rsp_cpsr},
               {1'b1, 1'b1, 2'b00, 1'b0, 4'h3, 4'b0000});
         if (c < 4) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_resume", req_ready, 2'b10);
      @(posedge clk);
      #1 req_valid = 2'b00;
      repeat (4) @(posedge clk);

      // Reset during second sweep pass
      #1;
      set_req(1, 4'd6, 4'd3, 2'b01, 2'b00, 2'd0, 1'b1);
      req_valid = 2'b10;
      @(negedge clk);
      check("rst6_accept", req_ready, 2'b10);
      @(posedge clk);
      #1 req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      check("rst6_pre", {busy, alu_kernelsel}, {1'b1, 2'd1});
      rst_n = 1'b0;
      #1;
      check("rst6_busy", {busy, rsp_valid}, 2'b00);
      check("rst6_alu", {alu_opa, alu_opb, alu_kernelsel, alu_funtype, alu_funcode}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst6_no_rsp", rsp_valid, 0);
      @(posedge clk);
      #1 req_valid = 2'b11;
      @(negedge clk);
      check("rst6_tie", req_ready, 2'b01);
      @(posedge clk);
      #1 req_valid = 2'b00;
      repeat (4) @(posedge clk);

      // Random traffic against the reference model
      do_reset();
      last_m = 1;
      outst = 0;
      seen = 0;
      acc_cyc = 0;
      for (int cyc = 0; cyc < 700; cyc++) begin
         @(negedge clk);
         acc = req_ready & req_valid;
         if (outst || req_valid == 2'b00) exp_ready = 2'b00;
         else begin
            g = (req_valid == 2'b11) ? 1 - last_m : int'(req_valid[1]);
            exp_ready = (g == 1) ? 2'b10 : 2'b01;
         end
         check("rnd_ready", req_ready, exp_ready);
         if (rsp_valid && !outst) check("rnd_spurious_rsp", rsp_valid, 0);
         if (rsp_valid && outst && !seen) begin
            seen = 1;
            check("rnd_latency", cyc - acc_cyc, q[0].lat);
         end
         if (rsp_valid && rsp_ready && q.size() > 0) begin
            e = q.pop_front();
            check("rnd_rsp", {rsp_id, rsp_result, rsp_cpsr}, {e.id, e.res, e.cp});
            last_m = int'(e.id);
            outst = 0;
         end
         if (|acc) begin
            g = int'(acc[1]);
            x = expect_f(req_opa[g*4 +: 4], req_opb[g*4 +: 4], req_funtype[g*2 +: 2],
                         req_funcode[g*2 +: 2], req_ksel[g*2 +: 2], req_sweep[g]);
            lat = req_sweep[g] ? 4 : 2;
            q.push_back('{acc[1], x[3:0], x[7:4], lat});
            outst = 1;
            seen = 0;
            acc_cyc = cyc;
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] || acc[i]) begin
               req_valid[i] = ($urandom_range(0, 3) != 0);
               set_req(i, 4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
                       2'($urandom), 1'($urandom_range(0, 2) == 0));
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (cyc >= 680) begin
            req_valid = 2'b00;
            rsp_ready = 1'b1;
         end
      end
      check("rnd_drain", {31'd0, outst}, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
